// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and constants (FSM states, parity modes, oversample/sample points)
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  localparam int OVERSAMPLE = 16;
  localparam int SAMP_A = 7;
  localparam int SAMP_B = 8;
  localparam int SAMP_C = 9;
endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-word bundle; master drives dout/dout_valid/parity_err/frame_err/break_det/overrun_err, slave drives dout_ready
interface uart_rx_param_if #(parameter int DATA_BITS = 8) ();
  logic [DATA_BITS-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic parity_err;
  logic frame_err;
  logic break_det;
  logic overrun_err;
  modport master(output dout, dout_valid, parity_err, frame_err, break_det, overrun_err, input dout_ready);
  modport slave(input dout, dout_valid, parity_err, frame_err, break_det, overrun_err, output dout_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick divider; in clk/rst/clr (hold counter at 0), out tick (one clk per DIV clocks)
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = (cnt_q == W'(DIV - 1)) && !clr;
    cnt_d = (clr || tick) ? '0 : cnt_q + W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: 16x-oversampled majority-vote UART receiver; in clk/rst/rxd/rx_en, out busy, rx_if (word+flags, valid/ready)
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16)
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  input  logic rx_en,
  output logic busy,
  uart_rx_param_if.master rx_if
);
  logic s1_q, rs_q, rs_prev_q;
  logic tick, maj, decide, bit_end, fin_ferr, brk, done;
  state_t state_q, state_d;
  logic [3:0] t_q, t_d, bit_q, bit_d;
  logic [1:0] samp_q, samp_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, dout_q, dout_d;
  logic perr_p_q, perr_p_d, ferr_p_q, ferr_p_d, zero_q, zero_d;
  logic valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d, ovr_q, ovr_d;
  always_ff @(posedge clk) begin
    if (rst) {s1_q, rs_q, rs_prev_q} <= '1;
    else {s1_q, rs_q, rs_prev_q} <= {rxd, s1_q, rs_q};
  end
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE),
    .tick(tick)
  );
  assign maj = (samp_q[1] & samp_q[0]) | (samp_q[1] & rs_q) | (samp_q[0] & rs_q);
  assign decide = tick && t_q == 4'(SAMP_C);
  assign bit_end = tick && t_q == 4'(OVERSAMPLE - 1);
  assign fin_ferr = ferr_p_q | ~maj;
  assign brk = zero_q & fin_ferr;
  assign done = state_q == STOP && decide && bit_q == 4'(STOP_BITS - 1);
  always_comb begin
    state_d = state_q;
    t_d = tick ? t_q + 4'd1 : t_q;
    bit_d = bit_q;
    sh_d = sh_q;
    perr_p_d = perr_p_q;
    ferr_p_d = ferr_p_q;
    zero_d = zero_q;
    samp_d[1] = (tick && t_q == 4'(SAMP_A)) ? rs_q : samp_q[1];
    samp_d[0] = (tick && t_q == 4'(SAMP_B)) ? rs_q : samp_q[0];
    unique case (state_q)
      IDLE: begin
        t_d = '0;
        bit_d = '0;
        if (rx_en && rs_prev_q && !rs_q) begin
          state_d = START;
          zero_d = 1'b1;
          perr_p_d = 1'b0;
          ferr_p_d = 1'b0;
        end
      end
      START: state_d = (decide && maj) ? IDLE : bit_end ? DATA : START;
      DATA: begin
        if (decide) begin
          sh_d = {maj, sh_q[DATA_BITS-1:1]};
          zero_d = zero_q & ~maj;
        end
        if (bit_end) begin
          bit_d = (bit_q == 4'(DATA_BITS - 1)) ? '0 : bit_q + 4'd1;
          if (bit_q == 4'(DATA_BITS - 1)) state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide) begin
          perr_p_d = maj != (^sh_q ^ (PARITY_MODE == PARITY_ODD));
          zero_d = zero_q & ~maj;
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (decide) ferr_p_d = fin_ferr;
        if (done) state_d = brk ? BRK_WAIT : IDLE;
        else if (bit_end) bit_d = bit_q + 4'd1;
      end
      BRK_WAIT: state_d = rs_q ? IDLE : BRK_WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dout_d = dout_q;
    valid_d = valid_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    brk_d = brk_q;
    ovr_d = 1'b0;
    if (done && valid_q && !rx_if.dout_ready) ovr_d = 1'b1;
    else if (done) begin
      dout_d = brk ? '0 : sh_q;
      valid_d = 1'b1;
      perr_d = perr_p_q;
      ferr_d = fin_ferr;
      brk_d = brk;
    end else if (valid_q && rx_if.dout_ready) valid_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;
      bit_q <= '0;
      samp_q <= '0;
      sh_q <= '0;
      perr_p_q <= 1'b0;
      ferr_p_q <= 1'b0;
      zero_q <= 1'b0;
      dout_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      brk_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      bit_q <= bit_d;
      samp_q <= samp_d;
      sh_q <= sh_d;
      perr_p_q <= perr_p_d;
      ferr_p_q <= ferr_p_d;
      zero_q <= zero_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      brk_q <= brk_d;
      ovr_q <= ovr_d;
    end
  end
  assign busy = state_q != IDLE;
  assign rx_if.dout = dout_q;
  assign rx_if.dout_valid = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.break_det = brk_q;
  assign rx_if.overrun_err = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param, one 8N1 and one 8E1 instance at 16 clk per bit
module tb_uart_rx_param;
  logic clk = 1'b0, rst = 1'b1, rx_en = 1'b1;
  logic rxd_n = 1'b1, rxd_e = 1'b1, rdy_n = 1'b1, rdy_e = 1'b1, busy_n, busy_e;
  int n_cmp = 0, n_bad = 0, hs_n = 0, hs_e = 0, vc_n = 0, ov_n = 0;
  logic [7:0] cd_n = '0, cd_e = '0;
  logic pe_n = 1'b0, fe_n = 1'b0, bk_n = 1'b0, pe_e = 1'b0, fe_e = 1'b0;
  always #5 clk = ~clk;
  uart_rx_param_if #(.DATA_BITS(8)) if_n ();
  uart_rx_param_if #(.DATA_BITS(8)) if_e ();
  assign if_n.dout_ready = rdy_n;
  assign if_e.dout_ready = rdy_e;
  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut_n (
    .clk(clk), .rst(rst), .rxd(rxd_n), .rx_en(rx_en), .busy(busy_n), .rx_if(if_n)
  );
  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY_MODE(1)) dut_e (
    .clk(clk), .rst(rst), .rxd(rxd_e), .rx_en(rx_en), .busy(busy_e), .rx_if(if_e)
  );
  always @(negedge clk) begin
    if (if_n.dout_valid) vc_n++;
    if (if_n.overrun_err) ov_n++;
    if (if_n.dout_valid && rdy_n) begin
      hs_n++;
      cd_n = if_n.dout;
      pe_n = if_n.parity_err;
      fe_n = if_n.frame_err;
      bk_n = if_n.break_det;
    end
    if (if_e.dout_valid && rdy_e) begin
      hs_e++;
      cd_e = if_e.dout;
      pe_e = if_e.parity_err;
      fe_e = if_e.frame_err;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic line(input bit e, input logic b);
    if (e) rxd_e = b;
    else rxd_n = b;
    cyc(16);
  endtask
  task automatic send(input bit e, input logic [7:0] d, input logic p, input logic stop);
    line(e, 1'b0);
    for (int i = 0; i < 8; i++) line(e, d[i]);
    if (e) line(e, p);
    line(e, stop);
    line(e, 1'b1);
  endtask
  initial begin
    cyc(4);
    @(negedge clk);
    chk("rst_dout", 32'(if_n.dout), 32'h0);
    chk("rst_valid", 32'(if_n.dout_valid), 32'h0);
    chk("rst_busy", 32'(busy_n), 32'h0);
    chk("rst_flags", 32'({if_n.parity_err, if_n.frame_err, if_n.break_det, if_n.overrun_err}), 32'h0);
    rst = 1'b0;
    cyc(4);
    vc_n = 0;
    hs_n = 0;
    send(1'b0, 8'hA5, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_dout", 32'(cd_n), 32'hA5);
    chk("t1_valid_cycles", 32'(vc_n), 32'd1);
    chk("t1_flags", 32'({pe_n, fe_n, bk_n}), 32'h0);
    chk("t1_ovr", 32'(ov_n), 32'd0);
    chk("t1_busy", 32'(busy_n), 32'h0);
    send(1'b1, 8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_dout_bad_par", 32'(cd_e), 32'h3C);
    chk("t2_perr_set", 32'(pe_e), 32'h1);
    chk("t2_ferr_clr", 32'(fe_e), 32'h0);
    send(1'b1, 8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_perr_clr", 32'(pe_e), 32'h0);
    chk("t2_count", 32'(hs_e), 32'd2);
    send(1'b0, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_dout", 32'(cd_n), 32'h55);
    chk("t3_ferr", 32'(fe_n), 32'h1);
    chk("t3_brk", 32'(bk_n), 32'h0);
    rdy_n = 1'b0;
    hs_n = 0;
    ov_n = 0;
    send(1'b0, 8'h11, 1'b0, 1'b1);
    send(1'b0, 8'h22, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_held_dout", 32'(if_n.dout), 32'h11);
    chk("t4_held_valid", 32'(if_n.dout_valid), 32'h1);
    chk("t4_ovr_pulses", 32'(ov_n), 32'd1);
    chk("t4_no_hs", 32'(hs_n), 32'd0);
    rdy_n = 1'b1;
    cyc(5);
    @(negedge clk);
    chk("t4_hs", 32'(hs_n), 32'd1);
    chk("t4_consumed", 32'(cd_n), 32'h11);
    chk("t4_valid_clr", 32'(if_n.dout_valid), 32'h0);
    hs_n = 0;
    rxd_n = 1'b0;
    cyc(4);
    rxd_n = 1'b1;
    cyc(40);
    @(negedge clk);
    chk("t5_glitch_busy", 32'(busy_n), 32'h0);
    chk("t5_glitch_novalid", 32'(hs_n), 32'd0);
    send(1'b0, 8'h0F, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5_dout", 32'(cd_n), 32'h0F);
    chk("t5_count", 32'(hs_n), 32'd1);
    chk("t5_ferr", 32'(fe_n), 32'h0);
    hs_n = 0;
    line(1'b0, 1'b0);
    line(1'b0, 1'b1);
    line(1'b0, 1'b0);
    rst = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("t5_rst_dout", 32'(if_n.dout), 32'h0);
    chk("t5_rst_busy", 32'(busy_n), 32'h0);
    chk("t5_rst_valid", 32'(if_n.dout_valid), 32'h0);
    chk("t5_rst_flags", 32'({if_n.frame_err, if_n.break_det}), 32'h0);
    rxd_n = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(200);
    @(negedge clk);
    chk("t5_rst_novalid", 32'(hs_n), 32'd0);
    rxd_n = 1'b0;
    cyc(480);
    @(negedge clk);
    chk("t6_one_frame", 32'(hs_n), 32'd1);
    chk("t6_dout", 32'(cd_n), 32'h0);
    chk("t6_brk", 32'(bk_n), 32'h1);
    chk("t6_ferr", 32'(fe_n), 32'h1);
    chk("t6_wait_busy", 32'(busy_n), 32'h1);
    rxd_n = 1'b1;
    cyc(40);
    @(negedge clk);
    chk("t6_idle", 32'(busy_n), 32'h0);
    chk("t6_no_more", 32'(hs_n), 32'd1);
    send(1'b0, 8'h7E, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_next_dout", 32'(cd_n), 32'h7E);
    chk("t6_next_flags", 32'({fe_n, bk_n}), 32'h0);
    chk("t6_count", 32'(hs_n), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
